// File: rtl/serial_capture_pkg.sv
// ----------------------------------------------------------------------------
// serial_capture_pkg : shared FSM type, default sync constants, clog2 helper
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_capture_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam int          DEF_SYNC_LEN  = 8;
  localparam logic [15:0] DEF_SYNC_WORD = 16'h00A5;

  // Returns at least 1 so that counters for a range of one still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_fifo2.sv
// ----------------------------------------------------------------------------
// sc_fifo2 : two-entry registered FIFO, push accepted when full if popping
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sc_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       count;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever survives the pop.
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop_data = head;
  assign valid    = (count != 2'd0);
  assign full     = (count == 2'd2);

endmodule

`default_nettype wire

// File: rtl/serial_capture.sv
// ----------------------------------------------------------------------------
// serial_capture : sync-word hunt, MSB-first frame deserialiser, buffered output
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_capture
  import serial_capture_pkg::*;
#(
  parameter int                  WIDTH       = 8,
  parameter int                  SYNC_LEN    = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = SYNC_LEN'(DEF_SYNC_WORD),
  parameter int                  FRAME_WORDS = 4,
  parameter int                  CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             in_frame,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int FILL_W = clog2(SYNC_LEN + 1);
  localparam int BIT_W  = clog2(WIDTH);
  localparam int WC_W   = clog2(FRAME_WORDS);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_LEN);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [WC_W-1:0]   WC_LAST   = WC_W'(FRAME_WORDS - 1);

  state_t state;
  state_t state_nxt;

  // Only the low SYNC_LEN-1 bits need storing; the incoming bit completes the window.
  logic [SYNC_LEN-2:0] window;
  logic [SYNC_LEN-1:0] win_shift;
  logic [FILL_W-1:0]   fill_cnt;
  logic [FILL_W-1:0]   fill_inc;
  logic [WIDTH-2:0]    shreg;
  logic [WIDTH-1:0]    word_shift;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WC_W-1:0]     word_cnt;

  logic sync_hit;
  logic word_done;
  logic frame_done;
  logic fifo_full;
  logic pop;
  logic drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sync_hit   = 1'b0;
    word_done  = 1'b0;
    frame_done = 1'b0;
    win_shift  = {window, bit_in};
    word_shift = {shreg, bit_in};
    fill_inc   = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + FILL_W'(1);
    if (bit_en) begin
      case (state)
        HUNT: begin
          sync_hit = (fill_inc == FILL_FULL) && (win_shift == SYNC_WORD);
          if (sync_hit) state_nxt = DATA;
        end
        DATA: begin
          word_done  = (bit_cnt == BIT_LAST);
          frame_done = word_done && (word_cnt == WC_LAST);
          if (frame_done) state_nxt = HUNT;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window   <= '0;
      fill_cnt <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (bit_en) begin
      if (state == HUNT) begin
        window   <= win_shift[SYNC_LEN-2:0];
        fill_cnt <= fill_inc;
      end else begin
        shreg <= word_shift[WIDTH-2:0];
        if (word_done) begin
          bit_cnt <= '0;
          if (frame_done) begin
            word_cnt <= '0;
            window   <= '0;
            fill_cnt <= '0;
          end else begin
            word_cnt <= word_cnt + WC_W'(1);
          end
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

  assign pop  = word_valid && word_ready;
  assign drop = word_done && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            ovf_count <= '0;
    else if (drop && (ovf_count != '1)) ovf_count <= ovf_count + CNT_W'(1);
  end

  sc_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_done),
    .push_data (word_shift),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (word_data),
    .valid     (word_valid)
  );

  assign in_frame = (state == DATA);

endmodule

`default_nettype wire

// File: tb/tb_serial_capture.sv
// ----------------------------------------------------------------------------
// tb_serial_capture : scoreboard bench for serial_capture
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_en;
  logic       word_ready;
  logic [7:0] word_data;
  logic       word_valid;
  logic       in_frame;
  logic [7:0] ovf_count;

  int         n_vec  = 0;
  int         n_miss = 0;
  int         n_pops = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serial_capture dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .in_frame   (in_frame),
    .ovf_count  (ovf_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change at negedge; by negedge+2 both inputs and outputs are what the next posedge uses.
  always begin
    @(negedge clk);
    #2;
    if (word_valid === 1'b1 && word_ready === 1'b1) begin
      n_pops++;
      if (exp_q.size() == 0) check("unexpected_pop", {24'd0, word_data}, 32'hFFFF_FFFF);
      else                   check("pop_word", {24'd0, word_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_in = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic send_bit_gap(input logic b);
    send_bit(b);
    @(negedge clk);
    bit_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_en = 1'b0;
    end
  endtask

  initial begin
    int pops0;
    logic [8:0] t5;
    rst = 1'b1; bit_in = 1'b0; bit_en = 1'b0; word_ready = 1'b1;
    @(negedge clk); #1;
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_data", {24'd0, word_data}, 32'd0);
    check("rst_in_frame", {31'd0, in_frame}, 32'd0);
    check("rst_ovf", {24'd0, ovf_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 1: sync then C3, plus three words to close the frame
    send_bits(8'hA5, 7);
    check("t1_pre_sync", {31'd0, in_frame}, 32'd0);
    send_bit(1'b1);
    check("t1_sync", {31'd0, in_frame}, 32'd1);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    check("t1_valid", {31'd0, word_valid}, 32'd1);
    check("t1_data", {24'd0, word_data}, 32'hC3);
    foreach (exp_q[i]) ;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(4);

    // 2: four words in order, then no output until a fresh sync
    pops0 = n_pops;
    send_byte(8'hA5);
    for (int w = 1; w <= 4; w++) exp_q.push_back(8'(w));
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_bits(8'h04, 7);
    check("t2_in_frame", {31'd0, in_frame}, 32'd1);
    send_bit(1'b0);
    check("t2_frame_end", {31'd0, in_frame}, 32'd0);
    idle(4);
    check("t2_pops", n_pops - pops0, 32'd4);
    send_byte(8'h01); send_byte(8'h01);
    idle(4);
    check("t2_no_resync", {31'd0, in_frame}, 32'd0);
    check("t2_no_words", n_pops - pops0, 32'd4);

    // 3: full backpressure, last two words dropped
    word_ready = 1'b0;
    send_byte(8'hA5);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(3);
    check("t3_valid", {31'd0, word_valid}, 32'd1);
    check("t3_head", {24'd0, word_data}, 32'h01);
    check("t3_ovf", {24'd0, ovf_count}, 32'd2);
    idle(3);
    check("t3_hold", {24'd0, word_data}, 32'h01);
    word_ready = 1'b1;
    idle(4);
    check("t3_drained", {31'd0, word_valid}, 32'd0);

    // 4: buffer full while the completing bit coincides with a pop
    word_ready = 1'b0;
    send_byte(8'hA5);
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    send_byte(8'h10); send_byte(8'h11);
    send_bits(8'h12, 7);
    word_ready = 1'b1;
    send_bit(1'b0);
    check("t4_valid", {31'd0, word_valid}, 32'd1);
    check("t4_head", {24'd0, word_data}, 32'h11);
    send_byte(8'h13);
    idle(4);
    check("t4_ovf", {24'd0, ovf_count}, 32'd2);

    // 5: sync embedded after a leading zero, bit_en every other cycle
    t5 = 9'b0_1010_0101;
    for (int i = 8; i >= 1; i--) send_bit_gap(t5[i]);
    check("t5_no_early", {31'd0, in_frame}, 32'd0);
    send_bit_gap(t5[0]);
    check("t5_sync", {31'd0, in_frame}, 32'd1);
    exp_q.push_back(8'h5A);
    for (int i = 7; i >= 1; i--) send_bit_gap(t5[i] ^ 1'b0 ? 8'h5A >> i : 8'h5A >> i);
    idle(5);
    check("t5_idle_hold", {31'd0, word_valid}, 32'd0);
    send_bit(1'b0);
    check("t5_word", {24'd0, word_data}, 32'h5A);
    exp_q.push_back(8'h81); exp_q.push_back(8'h42); exp_q.push_back(8'h24);
    send_byte(8'h81); send_byte(8'h42); send_byte(8'h24);
    check("t5_frame_end", {31'd0, in_frame}, 32'd0);
    idle(4);

    // 6: asynchronous reset mid-word with one word buffered
    word_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h77);
    send_bits(8'hF0, 5);
    check("t6_pre_valid", {31'd0, word_valid}, 32'd1);
    @(negedge clk);
    bit_en = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, word_valid}, 32'd0);
    check("t6_rst_data", {24'd0, word_data}, 32'd0);
    check("t6_rst_in_frame", {31'd0, in_frame}, 32'd0);
    check("t6_rst_ovf", {24'd0, ovf_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    word_ready = 1'b1;
    send_byte(8'h01); send_byte(8'h01);
    idle(3);
    check("t6_need_sync", {31'd0, in_frame}, 32'd0);
    check("t6_no_word", {31'd0, word_valid}, 32'd0);
    send_byte(8'hA5);
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC0);
    exp_q.push_back(8'h0C); exp_q.push_back(8'hFF);
    send_byte(8'h3C); send_byte(8'hC0); send_byte(8'h0C); send_byte(8'hFF);
    idle(6);
    check("t6_ovf", {24'd0, ovf_count}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
